// File: rtl/mul_seq_param.sv
// Iterative RV64 M-extension multiplier (MUL/MULH/MULHSU/MULHU), STEP bits per cycle.
// Ports: clk, rst_n, start, kill, op, a, b -> busy, done, s (selected word), p (full product).
module mul_seq_param #(
  parameter int WIDTH = 64,
  parameter int STEP  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               kill,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   s,
  output logic [2*WIDTH-1:0] p
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [W2-1:0]    ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    p_q, p_d;
  logic [WIDTH-1:0] s_q, s_d;

  logic             sgn_a, sgn_b;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [W2-1:0]    pp, sum, res;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    s_d     = s_q;

    sgn_a = (op == 2'b01) || (op == 2'b10);
    sgn_b = (op == 2'b01);
    neg_a = sgn_a & a[WIDTH-1];
    neg_b = sgn_b & b[WIDTH-1];
    abs_a = neg_a ? -a : a;
    abs_b = neg_b ? -b : b;

    // multiplicand is pre-shifted each cycle, so the partial
    // product needs no variable shifter
    pp  = ma_q * {{(W2-STEP){1'b0}}, mb_q[STEP-1:0]};
    sum = acc_q + pp;
    res = neg_q ? -sum : sum;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d  = op;
          neg_d = neg_a ^ neg_b;
          ma_d  = {{WIDTH{1'b0}}, abs_a};
          mb_d  = abs_b;
          acc_d = '0;
          cnt_d = '0;
          if (a == '0 || b == '0) begin
            p_d     = '0;
            s_d     = '0;
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          acc_d = sum;
          ma_d  = ma_q << STEP;
          mb_d  = mb_q >> STEP;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            p_d     = res;
            s_d     = (op_q == 2'b00) ? res[WIDTH-1:0]
                                      : res[W2-1:WIDTH];
            state_d = FIN;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      neg_q   <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      s_q     <= s_d;
    end
  end

  assign busy = (state_q != IDLE);
  // a kill landing in FIN swallows the pulse
  assign done = (state_q == FIN) && !kill;
  assign s    = s_q;
  assign p    = p_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Directed self-checking bench for mul_seq_param.
// Three instances: STEP=4 (idx0), STEP=1 (idx1), STEP=8 (idx2).
module tb_mul_seq_param;

  logic         clk;
  logic         rst_n;
  logic         kill;
  logic [1:0]   op;
  logic [63:0]  a, b;
  logic [2:0]   start_v, busy_v, done_v;
  logic [63:0]  s_v [3];
  logic [127:0] p_v [3];

  int errors;
  int checks;

  mul_seq_param #(.WIDTH(64), .STEP(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .kill(kill),
    .op(op), .a(a), .b(b), .busy(busy_v[0]), .done(done_v[0]),
    .s(s_v[0]), .p(p_v[0])
  );

  mul_seq_param #(.WIDTH(64), .STEP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .kill(kill),
    .op(op), .a(a), .b(b), .busy(busy_v[1]), .done(done_v[1]),
    .s(s_v[1]), .p(p_v[1])
  );

  mul_seq_param #(.WIDTH(64), .STEP(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .kill(kill),
    .op(op), .a(a), .b(b), .busy(busy_v[2]), .done(done_v[2]),
    .s(s_v[2]), .p(p_v[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // entered and left at posedge+1; start is high during cycle 0
  task automatic run_op(input int idx, input logic [1:0] o,
                        input logic [63:0] x, input logic [63:0] y,
                        input int maxc, output int dc, output int bc,
                        output int nd, output logic [63:0] sd,
                        output logic [127:0] pd);
    dc = -1; bc = 0; nd = 0; sd = '0; pd = '0;
    op = o; a = x; b = y;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    op = ~o; a = ~x; b = ~y;
    for (int c = 1; c <= maxc; c++) begin
      @(negedge clk);
      if (busy_v[idx]) bc++;
      if (done_v[idx]) begin
        nd++;
        if (dc < 0) begin
          dc = c; sd = s_v[idx]; pd = p_v[idx];
        end
      end
      @(posedge clk); #1;
    end
    op = '0; a = '0; b = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; kill = 1'b0; start_v = '0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (busy_v[i] !== 1'b0 || done_v[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d]: busy=%b done=%b want 0 0",
                 i, busy_v[i], done_v[i]);
      end
      checks++;
      if (s_v[i] !== 64'h0 || p_v[i] !== 128'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: s=%h p=%h want 0",
                 i, s_v[i], p_v[i]);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mulhu();
    int dc, bc, nd;
    logic [63:0] sd;
    logic [127:0] pd;
    run_op(0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           24, dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 17 || nd !== 1) begin
      errors++;
      $display("FAIL mulhu_lat: done_cycle=%0d n=%0d want 17 1", dc, nd);
    end
    checks++;
    if (bc !== 17) begin
      errors++;
      $display("FAIL mulhu_busy: cycles=%0d want 17", bc);
    end
    checks++;
    if (sd !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL mulhu_s: got %h want fffffffffffffffe", sd);
    end
    checks++;
    if (pd !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++;
      $display("FAIL mulhu_p: got %h", pd);
    end
  endtask

  task automatic test_zero_exit();
    int dc, bc, nd;
    logic [63:0] sd;
    logic [127:0] pd;
    run_op(0, 2'b01, 64'h0, 64'h1234, 20, dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 1 || nd !== 1 || bc !== 1) begin
      errors++;
      $display("FAIL zero_lat: done_cycle=%0d n=%0d busy=%0d want 1 1 1",
               dc, nd, bc);
    end
    checks++;
    if (sd !== 64'h0 || pd !== 128'h0) begin
      errors++;
      $display("FAIL zero_val: s=%h p=%h want 0", sd, pd);
    end
  endtask

  task automatic test_signed();
    int dc, bc, nd;
    logic [63:0] sd;
    logic [127:0] pd;
    run_op(0, 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           20, dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 17 || sd !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL mulh_s: cyc=%0d s=%h want 17 4000000000000000", dc, sd);
    end
    checks++;
    if (pd !== {64'h4000_0000_0000_0000, 64'h0}) begin
      errors++;
      $display("FAIL mulh_p: got %h", pd);
    end
    run_op(0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 20, dc, bc, nd, sd, pd);
    checks++;
    if (sd !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL mulhsu_s: got %h want ffffffffffffffff", sd);
    end
    checks++;
    if (pd !== {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      errors++;
      $display("FAIL mulhsu_p: got %h want -2", pd);
    end
  endtask

  task automatic test_back_to_back();
    int nd;
    nd = 0;
    op = 2'b00; a = 64'h1234; b = 64'h10;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 30; c++) begin
      start_v[0] = (c == 3);
      a = 64'h1; b = 64'h1;
      @(negedge clk);
      if (done_v[0]) nd++;
      @(posedge clk); #1;
    end
    start_v[0] = 1'b0;
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL busy_start: dones=%0d want 1", nd);
    end
    checks++;
    if (s_v[0] !== 64'h12340 || p_v[0] !== 128'h12340) begin
      errors++;
      $display("FAIL busy_start_val: s=%h p=%h want 12340", s_v[0], p_v[0]);
    end
  endtask

  task automatic test_kill();
    int nd, dc, bc;
    logic [63:0] sd;
    logic [127:0] pd;
    nd = 0;
    op = 2'b11; a = '1; b = '1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 25; c++) begin
      kill = (c == 5);
      start_v[0] = (c == 5);
      @(negedge clk);
      if (done_v[0]) nd++;
      if (c == 6) begin
        checks++;
        if (busy_v[0] !== 1'b0) begin
          errors++;
          $display("FAIL kill_idle: busy=%b want 0 in cycle 6", busy_v[0]);
        end
      end
      @(posedge clk); #1;
    end
    kill = 1'b0; start_v[0] = 1'b0;
    checks++;
    if (nd !== 0) begin
      errors++;
      $display("FAIL kill_done: dones=%0d want 0", nd);
    end
    checks++;
    if (s_v[0] !== 64'h12340 || p_v[0] !== 128'h12340) begin
      errors++;
      $display("FAIL kill_hold: s=%h p=%h want 12340", s_v[0], p_v[0]);
    end
    run_op(0, 2'b00, 64'd3, 64'd5, 20, dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 17 || sd !== 64'd15 || pd !== 128'd15) begin
      errors++;
      $display("FAIL kill_after: cyc=%0d s=%h p=%h want 17 f f", dc, sd, pd);
    end
  endtask

  task automatic test_steps();
    int dc, bc, nd;
    logic [63:0] sd;
    logic [127:0] pd;
    run_op(1, 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 70,
           dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 65 || nd !== 1) begin
      errors++;
      $display("FAIL step1_lat: done_cycle=%0d n=%0d want 65 1", dc, nd);
    end
    checks++;
    if (sd !== 64'hFFFF_FFFF_FFFF_FFEB ||
        pd !== {64'h6, 64'hFFFF_FFFF_FFFF_FFEB}) begin
      errors++;
      $display("FAIL step1_val: s=%h p=%h", sd, pd);
    end
    run_op(2, 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 14,
           dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 9 || nd !== 1 || bc !== 9) begin
      errors++;
      $display("FAIL step8_lat: done_cycle=%0d n=%0d busy=%0d want 9 1 9",
               dc, nd, bc);
    end
    checks++;
    if (sd !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL step8_s: got %h want ffffffffffffffeb", sd);
    end
  endtask

  task automatic test_async_reset();
    int dc, bc, nd;
    logic [63:0] sd;
    logic [127:0] pd;
    op = 2'b11; a = '1; b = '1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL arst_ctl: busy=%b done=%b want 0 0",
               busy_v[0], done_v[0]);
    end
    checks++;
    if (s_v[0] !== 64'h0 || p_v[0] !== 128'h0 || s_v[1] !== 64'h0) begin
      errors++;
      $display("FAIL arst_data: s=%h p=%h s1=%h want 0",
               s_v[0], p_v[0], s_v[1]);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 20,
           dc, bc, nd, sd, pd);
    checks++;
    if (dc !== 17 || nd !== 1 || sd !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL arst_after: cyc=%0d n=%0d s=%h want 17 1 ..ffeb",
               dc, nd, sd);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_mulhu();
    test_zero_exit();
    test_signed();
    test_back_to_back();
    test_kill();
    test_steps();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_seq_param.md
Name: mul_seq_param

Overview:
- Parametrised, mode-aware, iterative integer multiplier for the RV64 datapath. Successor to the fixed 64-bit unsigned multiplier unit.
- Supports the four RISC-V M-extension products: MUL, MULH, MULHSU and MULHU.
- Width and bits retired per cycle are configurable, so area and latency can be traded.
- Uses the same start/done handshake, plus a pipeline-flush kill and a zero-operand early exit.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of STEP and at least 8.
- STEP, 1, multiplier bits retired per CALC cycle; power of two in 1..8 that divides WIDTH.
- Derived N = WIDTH/STEP, the number of CALC cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- kill  in  1  synchronous abort of an in-flight operation.
- op  in  2  mode: 00 MUL (low word), 01 MULH (signed×signed, high), 10 MULHSU (a signed × b unsigned, high), 11 MULHU (unsigned, high).
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high in CALC and FIN.
- done  out  1  one-cycle pulse; s and p are valid while it is high.
- s  out  WIDTH  selected result: p[WIDTH-1:0] for MUL, p[2*WIDTH-1:WIDTH] otherwise.
- p  out  2*WIDTH  full two's-complement product under the signedness implied by op. For MUL, operands are treated as unsigned; s is identical either way.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, s=0, p=0; all internal registers cleared. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIN.
- IDLE, start=1:
  - Latch op.
  - Signed operands are latched as magnitudes: |a| if op∈{01,10}, |b| if op=01; otherwise raw.
  - neg = sign(a)&signed_a XOR sign(b)&signed_b.
  - Clear the 2*WIDTH accumulator; cnt=0.
  - If a==0 or b==0, go to FIN with the product forced to 0. Otherwise go to CALC.
- IDLE, start=0: stay; outputs hold their last values.
- CALC, each cycle:
  - acc += (mag_a × mag_b[STEP-1:0]) << (cnt*STEP).
  - mag_b >>= STEP; cnt++.
  - On the cycle with cnt==N-1, register the final result in the same edge: p = neg ? -acc_next : acc_next (2*WIDTH-bit two's complement), and s is selected from it. Then go to FIN.
- FIN: done=1 for exactly one cycle, then IDLE. s and p hold until the next completed operation.
- Latency (start high in cycle 0):
  - Normal operation: CALC occupies cycles 1..N; done is high in cycle N+1.
  - Zero early exit: done is high in cycle 1, s=0, p=0.
- Magnitude of the most-negative value (2^(WIDTH-1)) fits WIDTH unsigned bits; no overflow special case is required.
- start while busy (CALC or FIN): ignored, no queuing. start is not accepted in the FIN cycle.
- kill=1 in CALC or FIN: next state IDLE; no done, or done suppressed if in FIN; s and p keep their previous values.
- kill has priority over start.
- kill in IDLE: start is ignored that cycle.
- Operand or op changes after acceptance have no effect.

Test Plan:
- WIDTH=64, STEP=4, op=11, a=b=0xFFFF_FFFF_FFFF_FFFF, start in cycle 0 -> done only in cycle 17; s=0xFFFF_FFFF_FFFF_FFFE; p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001; busy high in cycles 1..17.
- op=01, a=b=0x8000_0000_0000_0000 -> s=0x4000_0000_0000_0000; p low word 0. Then op=10, a=-1 (all ones), b=2 -> s=0xFFFF_FFFF_FFFF_FFFF, p=-2.
- op=00, a=-3, b=7, STEP=1 -> s=0xFFFF_FFFF_FFFF_FFEB; done in cycle 65. Rerun with STEP=8 -> identical s; done in cycle 9.
- op=01, a=0, b=0x1234 -> done in cycle 1; s=0; p=0; busy high only in cycle 1.
- Start an op, pulse kill in cycle 5 with start also high -> no done; s and p unchanged; IDLE in cycle 6. A following start completes normally. start pulsed in cycle 3 of a running op -> ignored, one done only.
- Drop rst_n mid-CALC, asynchronously between edges -> busy, done, s, p go to 0 immediately. After release, the first start yields a correct result.
